vector_runner: RTL and testbench

Synthesizable stimulus/response engine for combinational netlist harnesses (ISCAS-class circuits such as c432). It fetches input vectors from a synchronous vector memory, drives them onto a DUT, waits a programmable settle time, samples the DUT outputs and streams each response out over a valid/ready port. It generalises fixed-width, fixed-count file-driven application to parametrised widths, run lengths, settle time and back-pressure, with optional on-chip response compaction.

---
 rtl/vector_runner_pkg.sv | 16 +
 rtl/vector_runner_if.sv | 24 ++
 rtl/vector_runner_misr.sv | 30 +++
 rtl/vector_runner.sv | 139 +++++++++++++
 tb/tb_vector_runner.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vector_runner_pkg.sv
// Shared types and constants for the vector_runner stimulus/response engine.
package vector_runner_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StApply,
    StSettle,
    StEmit,
    StFinish
  } state_e;

  localparam int unsigned SETTLE_MIN = 1;
  localparam logic [6:0] MISR_POLY_DEFAULT = 7'h41;

endpackage

// File: rtl/vector_runner_if.sv
// Vector-memory read port and response stream of vector_runner, grouped as one bundle.
interface vector_runner_if #(
  parameter int unsigned IN_W   = 36,
  parameter int unsigned OUT_W  = 7,
  parameter int unsigned ADDR_W = 14
);
  logic              vec_rd;
  logic [ADDR_W-1:0] vec_addr;
  logic [IN_W-1:0]   vec_data;
  logic              resp_valid;
  logic              resp_ready;
  logic [OUT_W-1:0]  resp_data;
  logic [ADDR_W-1:0] resp_idx;

  modport master (
    output vec_rd, vec_addr, resp_valid, resp_data, resp_idx,
    input  vec_data, resp_ready
  );

  modport slave (
    input  vec_rd, vec_addr, resp_valid, resp_data, resp_idx,
    output vec_data, resp_ready
  );
endinterface

// File: rtl/vector_runner_misr.sv
// Multiple-input signature register compacting accepted responses.
module vector_runner_misr #(
  parameter int unsigned   W    = 7,
  parameter logic [W-1:0]  POLY = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] data,
  output logic [W-1:0] sig
);
  logic [W-1:0] sig_d, sig_q;

  always_comb begin
    sig_d = sig_q;
    if (clr) begin
      sig_d = '0;
    end else if (en) begin
      sig_d = {sig_q[W-2:0], 1'b0} ^ (sig_q[W-1] ? POLY : '0) ^ data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sig_q <= '0;
    else        sig_q <= sig_d;
  end

  assign sig = sig_q;
endmodule

// File: rtl/vector_runner.sv
// Fetches vectors, drives them onto a combinational DUT, samples after a settle time and
// streams responses out. Define MISR_EN to add on-chip response compaction.
module vector_runner
  import vector_runner_pkg::*;
#(
  parameter int unsigned       IN_W      = 36,
  parameter int unsigned       OUT_W     = 7,
  parameter int unsigned       DEPTH     = 10000,
  parameter int unsigned       ADDR_W    = $clog2(DEPTH),
  parameter int unsigned       SETTLE    = 1,
  parameter logic [OUT_W-1:0]  MISR_POLY = OUT_W'(MISR_POLY_DEFAULT)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [ADDR_W:0]    num_vec,
  vector_runner_if.master    bus,
  output logic [IN_W-1:0]    dut_in,
  input  logic [OUT_W-1:0]   dut_out,
  output logic               busy,
  output logic               done,
  output logic [OUT_W-1:0]   signature
);
  localparam int unsigned SettleEff  = (SETTLE < SETTLE_MIN) ? SETTLE_MIN : SETTLE;
  localparam int unsigned CntW       = $clog2(SettleEff + 1);
  localparam logic [CntW-1:0] SettleInit = CntW'(SettleEff);
  localparam logic [ADDR_W:0] DepthV = (ADDR_W+1)'(DEPTH);

  state_e            state_d, state_q;
  logic [ADDR_W-1:0] idx_d, idx_q;
  logic [ADDR_W:0]   count_d, count_q;
  logic [CntW-1:0]   settle_d, settle_q;
  logic [IN_W-1:0]   dut_in_d, dut_in_q;
  logic [OUT_W-1:0]  resp_data_d, resp_data_q;
  logic [ADDR_W-1:0] resp_idx_d, resp_idx_q;
  logic [ADDR_W:0]   num_clamped;
  logic              misr_clr, misr_en;

  assign num_clamped = (num_vec > DepthV) ? DepthV : num_vec;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    count_d     = count_q;
    settle_d    = settle_q;
    dut_in_d    = dut_in_q;
    resp_data_d = resp_data_q;
    resp_idx_d  = resp_idx_q;
    misr_clr    = 1'b0;
    misr_en     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          count_d  = num_clamped;
          idx_d    = '0;
          misr_clr = 1'b1;
          state_d  = (num_clamped == '0) ? StFinish : StFetch;
        end
      end
      StFetch: state_d = StApply;
      StApply: begin
        dut_in_d = bus.vec_data;
        settle_d = SettleInit;
        state_d  = StSettle;
      end
      StSettle: begin
        settle_d = settle_q - CntW'(1);
        // Last settle cycle: the DUT has had SETTLE full cycles since dut_in changed.
        if (settle_q == CntW'(1)) begin
          resp_data_d = dut_out;
          resp_idx_d  = idx_q;
          state_d     = StEmit;
        end
      end
      StEmit: begin
        if (bus.resp_ready) begin
          misr_en = 1'b1;
          idx_d   = idx_q + ADDR_W'(1);
          state_d = (({1'b0, idx_q} + (ADDR_W+1)'(1)) == count_q) ? StFinish : StFetch;
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    // Abort wins over any in-flight handshake; dut_in is left untouched.
    if (abort && state_q != StIdle) begin
      state_d = StIdle;
      misr_en = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      count_q     <= '0;
      settle_q    <= '0;
      dut_in_q    <= '0;
      resp_data_q <= '0;
      resp_idx_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      count_q     <= count_d;
      settle_q    <= settle_d;
      dut_in_q    <= dut_in_d;
      resp_data_q <= resp_data_d;
      resp_idx_q  <= resp_idx_d;
    end
  end

  assign bus.vec_rd     = (state_q == StFetch);
  assign bus.vec_addr   = idx_q;
  assign bus.resp_valid = (state_q == StEmit);
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_idx   = resp_idx_q;
  assign dut_in         = dut_in_q;
  assign busy           = (state_q != StIdle);
  assign done           = (state_q == StFinish);

`ifdef MISR_EN
  vector_runner_misr #(
    .W    (OUT_W),
    .POLY (MISR_POLY)
  ) u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (misr_clr),
    .en    (misr_en),
    .data  (resp_data_q),
    .sig   (signature)
  );
`else
  logic unused_misr;
  assign unused_misr = ^{misr_clr, misr_en, MISR_POLY};
  assign signature   = '0;
`endif
endmodule

// File: tb/tb_vector_runner.sv
// Directed bench for vector_runner: scoreboard of expected responses plus literal pins.
module tb_vector_runner;
  localparam int unsigned IN_W   = 36;
  localparam int unsigned OUT_W  = 7;
  localparam int unsigned DEPTH  = 10000;
  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned SETTLE = 1;

  typedef struct {
    logic [OUT_W-1:0] data;
    int               idx;
    logic [IN_W-1:0]  vec;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              ready = 1'b1;
  logic [ADDR_W:0]   num_vec = '0;
  logic [IN_W-1:0]   dut_in;
  logic [OUT_W-1:0]  dut_out;
  logic [OUT_W-1:0]  signature;
  logic              busy, done;

  logic [IN_W-1:0]   mem [16];
  exp_t              exp_q [$];
  logic [OUT_W-1:0]  got_data [$];
  logic [OUT_W-1:0]  sig_model = '0;
  int                checks = 0;
  int                errors = 0;
  int                rd_count = 0;
  int                hs_count = 0;

  vector_runner_if #(.IN_W(IN_W), .OUT_W(OUT_W), .ADDR_W(ADDR_W)) bus ();

  vector_runner #(
    .IN_W      (IN_W),
    .OUT_W     (OUT_W),
    .DEPTH     (DEPTH),
    .ADDR_W    (ADDR_W),
    .SETTLE    (SETTLE),
    .MISR_POLY (7'h41)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .num_vec   (num_vec),
    .bus       (bus),
    .dut_in    (dut_in),
    .dut_out   (dut_out),
    .busy      (busy),
    .done      (done),
    .signature (signature)
  );

  always #5 clk = ~clk;

  // Synchronous vector memory and identity harness on the low output bits.
  always @(posedge clk) if (bus.vec_rd) bus.vec_data <= mem[bus.vec_addr[3:0]];
  assign bus.resp_ready = ready;
  assign dut_out        = dut_in[OUT_W-1:0];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [OUT_W-1:0] exp_sig();
`ifdef MISR_EN
    return sig_model;
`else
    return '0;
`endif
  endfunction

  // Compare process: every EMIT cycle against the scoreboard head.
  always @(negedge clk) begin
    if (bus.vec_rd) rd_count++;
    if (!rst_n || (start && !busy && !abort)) sig_model = '0;
    if (rst_n && bus.resp_valid) begin
      if (exp_q.size() == 0) begin
        check("resp_unexpected", 64'd1, 64'd0);
      end else begin
        check("resp_data", bus.resp_data, exp_q[0].data);
        check("resp_idx", bus.resp_idx, exp_q[0].idx);
        check("dut_in_hold", dut_in, exp_q[0].vec);
        check("fetch_while_pending", bus.vec_rd, 0);
        if (ready) begin
          hs_count++;
          got_data.push_back(bus.resp_data);
          sig_model = {sig_model[OUT_W-2:0], 1'b0} ^ (sig_model[OUT_W-1] ? 7'h41 : 7'h00)
                      ^ exp_q[0].data;
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic check_reset(input string tag);
    check({tag, "_vec_rd"}, bus.vec_rd, 0);
    check({tag, "_vec_addr"}, bus.vec_addr, 0);
    check({tag, "_dut_in"}, dut_in, 0);
    check({tag, "_resp_valid"}, bus.resp_valid, 0);
    check({tag, "_resp_data"}, bus.resp_data, 0);
    check({tag, "_resp_idx"}, bus.resp_idx, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_signature"}, signature, 0);
  endtask

  // One run: optional stall of the first EMIT, abort at a cycle, or a start pulse mid-run.
  task automatic do_run(input int n, input int stall, input int abort_at, input int restart_at);
    int lat;
    int stall_cnt;
    int rd0;
    int hs0;
    bit got_done;
    rd0 = rd_count;
    hs0 = hs_count;
    stall_cnt = 0;
    got_done = 1'b0;
    for (int k = 0; k < n; k++) begin
      exp_t e;
      e.data = mem[k][OUT_W-1:0];
      e.idx  = k;
      e.vec  = mem[k];
      exp_q.push_back(e);
    end
    ready   = (stall == 0);
    num_vec = (ADDR_W+1)'(n);
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat   = 1;
    while (lat < 500) begin
      if (done) begin
        got_done = 1'b1;
        break;
      end
      if (abort_at != 0 && lat == abort_at) begin
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        lat++;
        break;
      end
      if (restart_at != 0 && lat == restart_at) begin
        start   = 1'b1;
        num_vec = 1;
      end else begin
        start = 1'b0;
      end
      if (bus.resp_valid && !ready) begin
        stall_cnt++;
        if (stall_cnt > stall) ready = 1'b1;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    ready = 1'b1;
    if (abort_at != 0) begin
      check("abort_busy", busy, 0);
      check("abort_valid", bus.resp_valid, 0);
      check("abort_hs", hs_count - hs0, abort_at / (SETTLE + 3));
      got_done = 1'b0;
      repeat (5) begin
        @(posedge clk); #1;
        if (done) got_done = 1'b1;
      end
      check("abort_no_done", got_done, 0);
      exp_q.delete();
    end else begin
      check("done_seen", got_done, 1);
      check("latency", lat, n * (SETTLE + 3) + 1 + stall);
      check("busy_at_done", busy, 1);
      check("rd_count", rd_count - rd0, n);
      check("hs_count", hs_count - hs0, n);
      check("queue_drained", exp_q.size(), 0);
      @(posedge clk); #1;
      check("done_pulse", done, 0);
      check("busy_after", busy, 0);
    end
    check("signature", signature, exp_sig());
  endtask

  initial begin
    int g;
    int rd0;
    int wait_cnt;
    mem[0] = 36'h1;
    mem[1] = 36'h2;
    mem[2] = 36'h3;
    for (int k = 3; k < 16; k++) mem[k] = '0;

    #2;
    check_reset("por");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("idle_no_rd", rd_count, 0);
    check("idle_busy", busy, 0);

    // Basic three-vector run.
    do_run(3, 0, 0, 0);
    g = got_data.size();
    check("lit_resp0", got_data[g-3], 7'h01);
    check("lit_resp1", got_data[g-2], 7'h02);
    check("lit_resp2", got_data[g-1], 7'h03);

    // Back-pressure on the first response.
    do_run(3, 5, 0, 0);

    // Mixed patterns with upper bits that must not reach the response.
    mem[0] = 36'hF_0000_0055;
    mem[1] = 36'h1_2345_672A;
    mem[2] = 36'h8_0000_0000;
    mem[3] = 36'hA_5A5A_5A7F;
    do_run(4, 0, 0, 0);
    g = got_data.size();
    check("lit_pat0", got_data[g-4], 7'h55);
    check("lit_pat1", got_data[g-3], 7'h2A);
    check("lit_pat2", got_data[g-2], 7'h00);
    check("lit_pat3", got_data[g-1], 7'h7F);
    check("lit_dut_in_hold", dut_in, 36'hA_5A5A_5A7F);

    // Empty run, then a start pulse while busy.
    do_run(0, 0, 0, 0);
    do_run(2, 0, 0, 3);

    // Abort during SETTLE of the second vector.
    do_run(4, 0, 7, 0);
    check("lit_abort_keep", dut_in, 36'h1_2345_672A);

    // Abort beats start in IDLE.
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    check("abort_wins_idle", busy, 0);

    // Compaction: 0x01 then 0x40.
    mem[0] = 36'h1;
    mem[1] = 36'h40;
    do_run(2, 0, 0, 0);
`ifdef MISR_EN
    check("lit_signature", signature, 7'h42);
`else
    check("lit_signature", signature, 7'h00);
`endif

    // Asynchronous reset in the middle of an EMIT stall.
    mem[2] = 36'h3;
    for (int k = 0; k < 3; k++) begin
      exp_t e;
      e.data = mem[k][OUT_W-1:0];
      e.idx  = k;
      e.vec  = mem[k];
      exp_q.push_back(e);
    end
    ready   = 1'b0;
    num_vec = 3;
    start   = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    wait_cnt = 0;
    while (!bus.resp_valid && wait_cnt < 20) begin
      @(posedge clk); #1;
      wait_cnt++;
    end
    check("emit_reached", bus.resp_valid, 1);
    #2 rst_n = 1'b0;
    #1 check_reset("mid_emit");
    exp_q.delete();
    rd0 = rd_count;
    @(posedge clk); #1;
    rst_n = 1'b1;
    ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("post_reset_no_rd", rd_count - rd0, 0);
    check("post_reset_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
